dac_cmd_sequencer: RTL and testbench

- Upstream feeder for the DAC SPI master. Holds a bank of per-channel DAC codes and, on a start request, emits a fixed init sequence followed by one 32-bit write-and-update command per channel.
- Words are presented on a valid/ready word interface that connects directly to the SPI master's sdo_data_i / sdo_valid_i / sdo_ready_o.
- Replaces manual single-word pokes with a deterministic, repeatable DAC programming sequence.

---
 rtl/dac_cfg_pkg.sv | 32 +++
 rtl/dac_ch_regfile.sv | 56 +++++
 rtl/dac_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_dac_cmd_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_cfg_pkg.sv
// Shared command codes, word layout and FSM state encoding for the DAC command sequencer.
// Pure definitions: no latency, no backpressure.
package dac_cfg_pkg;

  localparam logic [3:0] CMD_SW_RESET = 4'hF;
  localparam logic [3:0] CMD_INT_REF  = 4'h7;
  localparam logic [3:0] CMD_WR_UPD   = 4'h3;

  localparam int WORD_CMD_LSB  = 20;
  localparam int WORD_ADDR_LSB = 16;
  localparam int WORD_CODE_LSB = 0;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INIT_RST = 3'd1;
  localparam logic [2:0] ST_SETTLE   = 3'd2;
  localparam logic [2:0] ST_INIT_REF = 3'd3;
  localparam logic [2:0] ST_CH_WR    = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  function automatic logic [31:0] make_word(input logic [3:0]  cmd,
                                            input logic [3:0]  addr,
                                            input logic [15:0] code);
    logic [31:0] w;
    w = '0;
    w[WORD_CMD_LSB  +: 4]  = cmd;
    w[WORD_ADDR_LSB +: 4]  = addr;
    w[WORD_CODE_LSB +: 16] = code;
    return w;
  endfunction

endpackage

// File: rtl/dac_ch_regfile.sv
// Per-channel DAC code store with write decode, bypassed read mux and (DAC_DIRTY_ONLY_EN) dirty bits.
// Write takes effect next cycle; read is combinational and sees a same-cycle write. No backpressure.
module dac_ch_regfile #(
  parameter int NUM_CH = 8,
  parameter int CODE_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [3:0]        wr_addr_i,
  input  logic [CODE_W-1:0] wr_data_i,
  input  logic [3:0]        rd_addr_i,
  output logic [15:0]       rd_code_o
`ifdef DAC_DIRTY_ONLY_EN
  ,
  input  logic              clr_en_i,
  input  logic [3:0]        clr_addr_i,
  output logic [NUM_CH-1:0] dirty_o
`endif
);

  logic [CODE_W-1:0] code_q [NUM_CH];
  logic [CODE_W-1:0] rd_raw;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) code_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (wr_en_i && wr_addr_i == 4'(i)) code_q[i] <= wr_data_i;
    end
  end

  // A write landing while the word is being captured must be the value that goes out.
  always_comb begin
    rd_raw = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_addr_i == 4'(i)) rd_raw = code_q[i];
    if (wr_en_i && wr_addr_i == rd_addr_i && int'(wr_addr_i) < NUM_CH) rd_raw = wr_data_i;
    rd_code_o = 16'(rd_raw) << (16 - CODE_W);
  end

`ifdef DAC_DIRTY_ONLY_EN
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      dirty_o <= '1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en_i && wr_addr_i == 4'(i))        dirty_o[i] <= 1'b1;
        else if (clr_en_i && clr_addr_i == 4'(i)) dirty_o[i] <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/dac_cmd_sequencer.sv
// DAC init + per-channel write-and-update word sequencer; DAC_DIRTY_ONLY_EN sends only changed channels.
// Word valid one cycle after state entry, GAP_CYC idle cycles after each transfer; holds word while ready low.
module dac_cmd_sequencer
  import dac_cfg_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int CODE_W     = 16,
  parameter int GAP_CYC    = 4,
  parameter int SETTLE_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              ch_wr_en_i,
  input  logic [3:0]        ch_wr_addr_i,
  input  logic [CODE_W-1:0] ch_wr_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       sdo_data_o,
  output logic              sdo_valid_o,
  input  logic              sdo_ready_i
);

  localparam bit NO_GAP = (GAP_CYC == 0);

  logic [2:0]        state, ret_state;
  logic              ret_all;
  logic [3:0]        ch_idx;
  logic [15:0]       cnt;
  logic              init_done, start_q;
  logic [15:0]       rd_code;
  logic [NUM_CH-1:0] send_mask;
  logic              any_first, any_next, present, xfer, start_pulse;
  logic [3:0]        first_idx, next_idx;
  logic [31:0]       word;

`ifdef DAC_DIRTY_ONLY_EN
  dac_ch_regfile #(.NUM_CH(NUM_CH), .CODE_W(CODE_W)) u_regfile (
    .clk_i(clk_i), .rst_n(rst_n),
    .wr_en_i(ch_wr_en_i), .wr_addr_i(ch_wr_addr_i), .wr_data_i(ch_wr_data_i),
    .rd_addr_i(ch_idx), .rd_code_o(rd_code),
    .clr_en_i(xfer && state == ST_CH_WR), .clr_addr_i(ch_idx), .dirty_o(send_mask)
  );
`else
  dac_ch_regfile #(.NUM_CH(NUM_CH), .CODE_W(CODE_W)) u_regfile (
    .clk_i(clk_i), .rst_n(rst_n),
    .wr_en_i(ch_wr_en_i), .wr_addr_i(ch_wr_addr_i), .wr_data_i(ch_wr_data_i),
    .rd_addr_i(ch_idx), .rd_code_o(rd_code)
  );
  assign send_mask = '1;
`endif

  assign start_pulse = start_i && !start_q;
  assign xfer        = sdo_valid_o && sdo_ready_i;
  assign present     = (state == ST_INIT_RST) || (state == ST_INIT_REF) || (state == ST_CH_WR);
  assign busy_o      = (state != ST_IDLE) && (state != ST_DONE);
  assign done_o      = (state == ST_DONE);

  // Lowest channel to send overall, and lowest one after the current index; skipping is free.
  always_comb begin
    any_first = 1'b0;
    first_idx = '0;
    any_next  = 1'b0;
    next_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (send_mask[i]) begin
        any_first = 1'b1;
        first_idx = 4'(i);
      end
      if (send_mask[i] && 4'(i) > ch_idx) begin
        any_next = 1'b1;
        next_idx = 4'(i);
      end
    end
  end

  always_comb begin
    case (state)
      ST_INIT_RST: word = make_word(CMD_SW_RESET, 4'd0, 16'h0000);
      ST_INIT_REF: word = make_word(CMD_INT_REF, 4'd0, 16'h0001);
      default:     word = make_word(CMD_WR_UPD, ch_idx, rd_code);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ret_state   <= ST_IDLE;
      ret_all     <= 1'b0;
      ch_idx      <= '0;
      cnt         <= '0;
      init_done   <= 1'b0;
      start_q     <= 1'b0;
      sdo_valid_o <= 1'b0;
      sdo_data_o  <= '0;
    end else begin
      start_q <= start_i;

      if (xfer) begin
        sdo_valid_o <= 1'b0;
      end else if (present && !sdo_valid_o) begin
        sdo_valid_o <= 1'b1;
        sdo_data_o  <= word;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (!start_pulse) begin
            state <= ST_IDLE;
          end else if (!init_done) begin
            state <= ST_INIT_RST;
          end else begin
            state  <= any_first ? ST_CH_WR : ST_DONE;
            ch_idx <= first_idx;
          end
        end
        ST_INIT_RST: if (xfer) begin
          cnt       <= '0;
          state     <= NO_GAP ? ST_SETTLE : ST_GAP;
          ret_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == 16'(SETTLE_CYC - 1)) state <= ST_INIT_REF;
          else                            cnt   <= cnt + 16'd1;
        end
        ST_INIT_REF: if (xfer) begin
          init_done <= 1'b1;
          cnt       <= '0;
          ret_state <= ST_CH_WR;
          ret_all   <= 1'b1;
          if (!NO_GAP)        state <= ST_GAP;
          else begin
            state  <= any_first ? ST_CH_WR : ST_DONE;
            ch_idx <= first_idx;
          end
        end
        ST_CH_WR: if (xfer) begin
          cnt       <= '0;
          ret_state <= ST_CH_WR;
          ret_all   <= 1'b0;
          if (!NO_GAP)       state <= ST_GAP;
          else begin
            state  <= any_next ? ST_CH_WR : ST_DONE;
            ch_idx <= next_idx;
          end
        end
        ST_GAP: begin
          if (cnt != 16'(GAP_CYC - 1)) begin
            cnt <= cnt + 16'd1;
          end else if (ret_state != ST_CH_WR) begin
            cnt   <= '0;
            state <= ret_state;
          end else if (ret_all) begin
            state  <= any_first ? ST_CH_WR : ST_DONE;
            ch_idx <= first_idx;
          end else begin
            state  <= any_next ? ST_CH_WR : ST_DONE;
            ch_idx <= next_idx;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_cmd_sequencer.sv
// Randomized self-checking bench for dac_cmd_sequencer against a channel-list reference model.
module tb_dac_cmd_sequencer;

  localparam int NCH = 8;
`ifdef DAC_DIRTY_ONLY_EN
  localparam bit DIRTY = 1'b1;
`else
  localparam bit DIRTY = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        ch_wr_en_i = 1'b0;
  logic [3:0]  ch_wr_addr_i = '0;
  logic [15:0] ch_wr_data_i = '0;
  logic        sdo_ready_i = 1'b1;
  logic        busy_o, done_o, sdo_valid_o;
  logic [31:0] sdo_data_o;

  always #5 clk_i = ~clk_i;

  dac_cmd_sequencer dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i),
    .ch_wr_en_i(ch_wr_en_i), .ch_wr_addr_i(ch_wr_addr_i), .ch_wr_data_i(ch_wr_data_i),
    .busy_o(busy_o), .done_o(done_o),
    .sdo_data_o(sdo_data_o), .sdo_valid_o(sdo_valid_o), .sdo_ready_i(sdo_ready_i)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] obs_q[$];
  int done_cnt = 0, hold_err = 0, stall_seen = 0;
  logic prev_v = 1'b0, prev_x = 1'b0;
  logic [31:0] prev_d = '0;
  int stall_at = -1, stall_cnt = 0;
  bit rdy_rand = 1'b0;

  logic [15:0] m_code[NCH];
  bit          m_dirty[NCH];
  bit          m_init;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Word monitor: transfers, handshake stability, stall cycles and done pulses.
  always @(negedge clk_i) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (prev_v && !prev_x && (!sdo_valid_o || sdo_data_o != prev_d)) hold_err <= hold_err + 1;
      if (sdo_valid_o && sdo_ready_i) obs_q.push_back(sdo_data_o);
      if (sdo_valid_o && !sdo_ready_i) stall_seen <= stall_seen + 1;
      if (done_o) done_cnt <= done_cnt + 1;
      prev_v <= sdo_valid_o;
      prev_x <= sdo_valid_o && sdo_ready_i;
      prev_d <= sdo_data_o;
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (obs_q.size() == stall_at && stall_cnt < 20) begin
      sdo_ready_i = 1'b0;
      if (sdo_valid_o) stall_cnt++;
    end else begin
      sdo_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (obs_q.size() != stall_at) stall_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_code[c]  = '0;
      m_dirty[c] = 1'b1;
    end
    m_init = 1'b0;
  endtask

  task automatic write_ch(input logic [3:0] a, input logic [15:0] d);
    ch_wr_en_i   = 1'b1;
    ch_wr_addr_i = a;
    ch_wr_data_i = d;
    step();
    ch_wr_en_i = 1'b0;
    if (a < NCH) begin
      m_code[a]  = d;
      m_dirty[a] = 1'b1;
    end
  endtask

  task automatic write_all_random(input logic [15:0] ch0);
    write_ch(4'd0, ch0);
    for (int c = 1; c < NCH; c++) write_ch(4'(c), 16'($urandom));
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // One full sequence: expected words are the init pair (if not yet initialised) then every
  // channel due for sending, in index order, with the model's code for it.
  task automatic run_seq(input string tag, input bit mid);
    int base, d0;
    bit init0, found;
    logic [31:0] exp_q[$];
    init0 = m_init;
    base  = obs_q.size();
    d0    = done_cnt;
    pulse_start();
    check_eq({tag, "_busy_rise"}, busy_o, 1'b1);
    if (mid) begin
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
        if (sdo_valid_o && sdo_data_o[23:16] == 8'h32) found = 1'b1;
        else step();
      end
      check_eq({tag, "_ch2_inflight"}, found, 1'b1);
      write_ch(4'd5, 16'h0ABC);
      pulse_start();
    end
    for (int k = 0; k < 4000 && done_cnt == d0; k++) step();
    check_eq({tag, "_done_seen"}, done_cnt > d0, 1'b1);
    repeat (30) step();
    if (!init0) begin
      exp_q.push_back(32'h00F0_0000);
      exp_q.push_back(32'h0070_0001);
    end
    for (int c = 0; c < NCH; c++)
      if (!DIRTY || m_dirty[c]) exp_q.push_back({8'h00, 4'h3, 4'(c), m_code[c]});
    check_eq({tag, "_nwords"}, obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i), obs_at(base + i), exp_q[i]);
    check_eq({tag, "_done_once"}, done_cnt - d0, 1);
    check_eq({tag, "_busy_end"}, busy_o, 1'b0);
    m_init = 1'b1;
    for (int c = 0; c < NCH; c++) m_dirty[c] = 1'b0;
  endtask

  initial begin
    int base, s0;
    bit found;
    model_reset();
    #2;
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_valid", sdo_valid_o, 1'b0);
    check_eq("rst_data", sdo_data_o, 32'h0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    step();

    // First sequence with init words
    base = obs_q.size();
    write_ch(4'd0, 16'h1234);
    write_ch(4'd7, 16'hFFFF);
    run_seq("seq1", 1'b0);
    check_eq("seq1_first", obs_at(base), 32'h00F0_0000);
    check_eq("seq1_ch0", obs_at(base + 2), 32'h0030_1234);
    check_eq("seq1_ch7", obs_at(base + 9), 32'h0037_FFFF);

    // Second start: no init words
    base = obs_q.size();
    write_all_random(16'h1234);
    run_seq("seq2", 1'b0);
    check_eq("seq2_first", obs_at(base), 32'h0030_1234);

    // Ready held low for 20 valid cycles on the third word
    write_all_random(16'($urandom));
    s0 = stall_seen;
    stall_at = obs_q.size() + 2;
    run_seq("stall", 1'b0);
    stall_at = -1;
    check_eq("stall_cycles", stall_seen - s0, 20);
    check_eq("stall_hold", hold_err, 0);

    // Mid-sequence channel write plus a start while busy
    write_all_random(16'($urandom));
    rdy_rand = 1'b1;
    base = obs_q.size();
    run_seq("mid", 1'b1);
    check_eq("mid_ch5", obs_at(base + 5), 32'h0035_0ABC);

    for (int it = 0; it < 4; it++) begin
      rdy_rand = 1'($urandom);
      for (int w = $urandom_range(0, 6); w > 0; w--)
        write_ch(4'($urandom), 16'($urandom));
      run_seq($sformatf("rnd%0d", it), 1'b0);
    end
    rdy_rand = 1'b0;

    // Reset during SETTLE, then init must be re-run
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    step();
    base = obs_q.size();
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (obs_q.size() > base) found = 1'b1;
      else step();
    end
    check_eq("settle_rst_word", found, 1'b1);
    repeat (12) step();
    check_eq("settle_rst_busy_pre", busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("settle_rst_valid", sdo_valid_o, 1'b0);
    check_eq("settle_rst_busy", busy_o, 1'b0);
    step();
    rst_n = 1'b1;
    model_reset();
    step();
    base = obs_q.size();
    run_seq("post_rst", 1'b0);
    check_eq("post_rst_first", obs_at(base), 32'h00F0_0000);

`ifdef DAC_DIRTY_ONLY_EN
    base = obs_q.size();
    write_ch(4'd3, 16'h0001);
    run_seq("dirty", 1'b0);
    check_eq("dirty_n", obs_q.size() - base, 1);
    check_eq("dirty_word", obs_at(base), 32'h0033_0001);
`endif

    check_eq("hold_total", hold_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
